// File: rtl/led_driver.sv
// led_driver: front-panel LED output stage with per-channel pulse stretching and glitch-free global PWM dimming.
// Stretch counters are built only when LED_STRETCH_EN is defined; otherwise channels pass straight through.
module led_driver #(
    parameter int N_LEDS         = 16,
    parameter int STRETCH_CYCLES = 4000000,
    parameter int PWM_BITS       = 4,
    parameter int PWM_PRESCALE   = 256
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [N_LEDS-1:0]   led_in,
    input  logic [N_LEDS-1:0]   stretch_mask,
    input  logic [PWM_BITS-1:0] brightness,
    input  logic                lamp_test,
    output logic [N_LEDS-1:0]   led_pin,
    output logic [PWM_BITS-1:0] pwm_phase
);

    localparam int PRE_W = (PWM_PRESCALE > 1) ? $clog2(PWM_PRESCALE) : 1;
    localparam logic [PRE_W-1:0]    PRE_MAX   = PRE_W'(PWM_PRESCALE - 1);
    localparam logic [PRE_W-1:0]    PRE_ONE   = PRE_W'(1);
    localparam logic [PWM_BITS-1:0] PHASE_ONE = PWM_BITS'(1);

    logic [N_LEDS-1:0]   in_p0;
    logic [N_LEDS-1:0]   stretched;
    logic [PRE_W-1:0]    pre;
    logic                tick;
    logic [PWM_BITS-1:0] bright_act;
    logic                pwm_on;

    // Stage 0: raw LED levels registered into the logic clock domain
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            in_p0 <= '0;
        end else begin
            in_p0 <= led_in;
        end
    end

`ifdef LED_STRETCH_EN
    localparam int CNT_W = $clog2(STRETCH_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STRETCH_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_p1 [N_LEDS];

    function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
        return (v == '0) ? v : v - CNT_ONE;
    endfunction

    // Stage 1: per-channel hold-off counters; a high input reloads, mask clear kills the stretch
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_LEDS; i++) begin
                cnt_p1[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_LEDS; i++) begin
                if (!stretch_mask[i]) begin
                    cnt_p1[i] <= '0;
                end else if (in_p0[i]) begin
                    cnt_p1[i] <= CNT_LOAD;
                end else begin
                    cnt_p1[i] <= sat_dec(cnt_p1[i]);
                end
            end
        end
    end

    always_comb begin
        stretched = in_p0;
        for (int i = 0; i < N_LEDS; i++) begin
            stretched[i] = in_p0[i] | (cnt_p1[i] != '0);
        end
    end
`else
    logic unused_stretch_mask;
    assign unused_stretch_mask = ^stretch_mask;
    assign stretched           = in_p0;
`endif

    assign tick = (pre == PRE_MAX);

    // Brightness is only adopted as the phase wraps, so a period is never cut short or extended
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pre        <= '0;
            pwm_phase  <= '0;
            bright_act <= '1;
        end else if (tick) begin
            pre       <= '0;
            pwm_phase <= pwm_phase + PHASE_ONE;
            if (pwm_phase == '1) begin
                bright_act <= brightness;
            end
        end else begin
            pre <= pre + PRE_ONE;
        end
    end

    assign pwm_on = (bright_act == '1) || (pwm_phase < bright_act);

    // Stage 1: registered pin drive; lamp test overrides both stretch and dimming
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            led_pin <= '0;
        end else begin
            led_pin <= lamp_test ? '1 : (stretched & {N_LEDS{pwm_on}});
        end
    end

endmodule

// File: tb/tb_led_driver.sv
// tb_led_driver: scoreboard bench for led_driver with short stretch and fast PWM parameters.
// Expectations follow the LED_STRETCH_EN build setting of the compilation.
module tb_led_driver;

    localparam int NL     = 16;
    localparam int SC     = 10;
    localparam int PRE    = 2;
    localparam int PERIOD = PRE * 16;
`ifdef LED_STRETCH_EN
    localparam bit STRETCH_EN = 1'b1;
`else
    localparam bit STRETCH_EN = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset_n;
    logic [NL-1:0] led_in;
    logic [NL-1:0] stretch_mask;
    logic [3:0]    brightness;
    logic          lamp_test;
    logic [NL-1:0] led_pin;
    logic [3:0]    pwm_phase;

    int checks = 0;
    int errors = 0;
    int ncyc   = 0;
    int dcount = 0;

    logic [15:0] exp_q [$];
    logic [3:0]  m_bact;
    bit          m_live [16];
    int          m_last [16];

    led_driver #(
        .N_LEDS(NL), .STRETCH_CYCLES(SC), .PWM_BITS(4), .PWM_PRESCALE(PRE)
    ) dut (
        .clock(clock), .reset_n(reset_n), .led_in(led_in), .stretch_mask(stretch_mask),
        .brightness(brightness), .lamp_test(lamp_test), .led_pin(led_pin), .pwm_phase(pwm_phase)
    );

    always #5 clock = ~clock;

    // edges seen by the DUT since reset was released
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) ncyc <= 0;
        else          ncyc <= ncyc + 1;
    end

    task automatic model_reset();
        m_bact = 4'hF;
        for (int i = 0; i < 16; i++) begin
            m_live[i] = 1'b0;
            m_last[i] = -1000;
        end
        exp_q.delete();
    endtask

    // Expected led_pin one edge after the edge that samples the inputs driven now
    task automatic model_push();
        logic [15:0] st;
        logic        on;
        int          n1;
        int          ph;
        bit          cnting;
        n1 = ncyc + 1;
        if (n1 % PERIOD == 0) m_bact = brightness;
        ph = (n1 / PRE) % 16;
        on = (m_bact == 4'hF) || (ph < int'(m_bact));
        for (int i = 0; i < 16; i++) begin
            cnting = STRETCH_EN && m_live[i] && stretch_mask[i] && (dcount - m_last[i] <= SC);
            st[i] = led_in[i] | cnting;
            if (!stretch_mask[i]) m_live[i] = 1'b0;
            if (led_in[i]) begin
                m_live[i] = 1'b1;
                m_last[i] = dcount;
            end
        end
        exp_q.push_back(on ? st : 16'h0000);
        dcount++;
    endtask

    task automatic step(output logic [15:0] got, output logic [15:0] want, output bit have);
        model_push();
        @(negedge clock);
        got  = led_pin;
        want = '0;
        have = 1'b0;
        if (exp_q.size() > 1) begin
            want = exp_q.pop_front();
            have = 1'b1;
        end
    endtask

    task automatic drain(output logic [15:0] got, output logic [15:0] want, output bit have);
        @(negedge clock);
        got  = led_pin;
        want = '0;
        have = 1'b0;
        if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            have = 1'b1;
        end
    endtask

    task automatic test_reset();
        logic [15:0] got, want;
        bit have;
        reset_n = 1'b0; led_in = 16'hFFFF; stretch_mask = '0; brightness = 4'hF; lamp_test = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if (led_pin !== 16'h0000) begin errors++; $display("FAIL reset_pin got=%h want=0000", led_pin); end
        checks++;
        if (pwm_phase !== 4'h0) begin errors++; $display("FAIL reset_phase got=%h want=0", pwm_phase); end
        model_reset();
        reset_n = 1'b1;
        step(got, want, have);
        checks++;
        if (got !== 16'h0000) begin errors++; $display("FAIL release_edge1 got=%h want=0000", got); end
        step(got, want, have);
        if (have) begin
            checks++;
            if (got !== want) begin errors++; $display("FAIL release_sb got=%h want=%h", got, want); end
        end
        checks++;
        if (got !== 16'hFFFF) begin errors++; $display("FAIL release_edge2 got=%h want=FFFF", got); end
    endtask

    task automatic test_stretch();
        logic [15:0] got, want;
        bit have;
        int n0, n1, f0, f1;
        led_in = '0; stretch_mask = 16'h0001;
        for (int t = 0; t < 14; t++) begin
            step(got, want, have);
            if (have) begin
                checks++;
                if (got !== want) begin errors++; $display("FAIL stretch_idle t=%0d got=%h want=%h", t, got, want); end
            end
        end
        n0 = 0; n1 = 0; f0 = -1; f1 = -1;
        for (int t = 0; t < 20; t++) begin
            led_in = (t == 1) ? 16'h0003 : 16'h0000;
            step(got, want, have);
            if (have) begin
                checks++;
                if (got !== want) begin errors++; $display("FAIL stretch_seq t=%0d got=%h want=%h", t, got, want); end
            end
            if (got[0]) begin n0++; if (f0 < 0) f0 = t; end
            if (got[1]) begin n1++; if (f1 < 0) f1 = t; end
        end
        checks++;
        if (n0 != (STRETCH_EN ? SC + 1 : 1)) begin errors++; $display("FAIL stretch_len0 got=%0d want=%0d", n0, STRETCH_EN ? SC + 1 : 1); end
        checks++;
        if (n1 != 1) begin errors++; $display("FAIL stretch_len1 got=%0d want=1", n1); end
        checks++;
        if (f0 != f1 || f0 < 0) begin errors++; $display("FAIL stretch_start got=%0d want=%0d", f0, f1); end
    endtask

    task automatic test_retrigger();
        logic [15:0] got, want;
        bit have;
        int n0;
        n0 = 0;
        stretch_mask = 16'h0001;
        for (int t = 0; t < 25; t++) begin
            led_in = (t == 1 || t == 6) ? 16'h0001 : 16'h0000;
            step(got, want, have);
            if (have) begin
                checks++;
                if (got !== want) begin errors++; $display("FAIL retrig_seq t=%0d got=%h want=%h", t, got, want); end
            end
            if (got[0]) n0++;
        end
        checks++;
        if (n0 != (STRETCH_EN ? 16 : 2)) begin errors++; $display("FAIL retrig_len got=%0d want=%0d", n0, STRETCH_EN ? 16 : 2); end
    endtask

    task automatic test_mask_clear();
        logic [15:0] got, want;
        bit have;
        int n0, l0;
        n0 = 0; l0 = -1;
        for (int t = 0; t < 20; t++) begin
            led_in       = (t == 1) ? 16'h0001 : 16'h0000;
            stretch_mask = (t >= 5) ? 16'h0000 : 16'h0001;
            step(got, want, have);
            if (have) begin
                checks++;
                if (got !== want) begin errors++; $display("FAIL mclr_seq t=%0d got=%h want=%h", t, got, want); end
            end
            if (got[0]) begin n0++; l0 = t; end
        end
        checks++;
        if (n0 != (STRETCH_EN ? 4 : 1)) begin errors++; $display("FAIL mclr_len got=%0d want=%0d", n0, STRETCH_EN ? 4 : 1); end
        checks++;
        if (l0 != (STRETCH_EN ? 5 : 2)) begin errors++; $display("FAIL mclr_drop got=%0d want=%0d", l0, STRETCH_EN ? 5 : 2); end
    endtask

    task automatic test_pwm();
        logic [15:0] got, want;
        bit have;
        int hi;
        logic [3:0] lvl [2];
        int req [2];
        lvl[0] = 4'h4; req[0] = 8;
        lvl[1] = 4'h0; req[1] = 0;
        led_in = 16'hFFFF; stretch_mask = '0;
        for (int k = 0; k < 2; k++) begin
            brightness = lvl[k];
            hi = 0;
            for (int t = 0; t < 3 * PERIOD; t++) begin
                step(got, want, have);
                if (have) begin
                    checks++;
                    if (got !== want) begin errors++; $display("FAIL pwm_seq b=%0d t=%0d got=%h want=%h", lvl[k], t, got, want); end
                end
                checks++;
                if (pwm_phase !== 4'((ncyc / PRE) % 16)) begin
                    errors++; $display("FAIL pwm_phase t=%0d got=%0d want=%0d", t, pwm_phase, (ncyc / PRE) % 16);
                end
                if (t >= 2 * PERIOD && got == 16'hFFFF) hi++;
            end
            checks++;
            if (hi != req[k]) begin errors++; $display("FAIL pwm_duty b=%0d got=%0d want=%0d", lvl[k], hi, req[k]); end
        end
    endtask

    task automatic test_glitch_free();
        logic [15:0] got, want;
        bit have, found;
        int hi;
        logic [3:0] prev;
        brightness = 4'h4;
        for (int t = 0; t < 3 * PERIOD; t++) begin
            step(got, want, have);
            if (have) begin
                checks++;
                if (got !== want) begin errors++; $display("FAIL glitch_pre t=%0d got=%h want=%h", t, got, want); end
            end
        end
        found = 1'b0;
        prev  = pwm_phase;
        for (int t = 0; t < 2 * PERIOD; t++) begin
            step(got, want, have);
            if (have) begin
                checks++;
                if (got !== want) begin errors++; $display("FAIL glitch_wait t=%0d got=%h want=%h", t, got, want); end
            end
            if (pwm_phase == 4'h2 && prev != 4'h2) begin
                found = 1'b1;
                break;
            end
            prev = pwm_phase;
        end
        checks++;
        if (!found) begin errors++; $display("FAIL glitch_phase2 got=none want=phase 2 within %0d cycles", 2 * PERIOD); end
        if (found) begin
            brightness = 4'h8;
            hi = 0;
            for (int t = 0; t < 28; t++) begin
                step(got, want, have);
                if (have) begin
                    checks++;
                    if (got !== want) begin errors++; $display("FAIL glitch_cur t=%0d got=%h want=%h", t, got, want); end
                end
                if (got == 16'hFFFF) hi++;
            end
            checks++;
            if (hi != 4) begin errors++; $display("FAIL glitch_cur_rest got=%0d want=4", hi); end
            hi = 0;
            for (int t = 0; t < PERIOD; t++) begin
                step(got, want, have);
                if (have) begin
                    checks++;
                    if (got !== want) begin errors++; $display("FAIL glitch_next t=%0d got=%h want=%h", t, got, want); end
                end
                if (got == 16'hFFFF) hi++;
            end
            checks++;
            if (hi != 16) begin errors++; $display("FAIL glitch_next_period got=%0d want=16", hi); end
        end
        brightness = 4'hF;
        for (int t = 0; t < 70; t++) begin
            step(got, want, have);
            if (have) begin
                checks++;
                if (got !== want) begin errors++; $display("FAIL glitch_restore t=%0d got=%h want=%h", t, got, want); end
            end
        end
    endtask

    task automatic test_lamp();
        logic [15:0] got, want;
        bit have;
        drain(got, want, have);
        if (have) begin
            checks++;
            if (got !== want) begin errors++; $display("FAIL lamp_drain got=%h want=%h", got, want); end
        end
        led_in = '0; lamp_test = 1'b1;
        @(negedge clock);
        checks++;
        if (led_pin !== 16'hFFFF) begin errors++; $display("FAIL lamp_on got=%h want=FFFF", led_pin); end
        stretch_mask = 16'h0001; led_in = 16'h0001;
        @(negedge clock);
        checks++;
        if (led_pin !== 16'hFFFF) begin errors++; $display("FAIL lamp_pulse got=%h want=FFFF", led_pin); end
        led_in = '0;
        @(negedge clock);
        @(negedge clock);
        checks++;
        if (led_pin !== 16'hFFFF) begin errors++; $display("FAIL lamp_hold got=%h want=FFFF", led_pin); end
        lamp_test = 1'b0;
        @(negedge clock);
        checks++;
        if (led_pin !== (STRETCH_EN ? 16'h0001 : 16'h0000)) begin
            errors++; $display("FAIL lamp_release got=%h want=%h", led_pin, STRETCH_EN ? 16'h0001 : 16'h0000);
        end
    endtask

    task automatic test_async_reset();
        stretch_mask = 16'h0001;
        led_in = 16'h0003;
        @(negedge clock);
        led_in = 16'h0002;
        @(negedge clock);
        @(negedge clock);
        checks++;
        if (led_pin !== (STRETCH_EN ? 16'h0003 : 16'h0002)) begin
            errors++; $display("FAIL areset_before got=%h want=%h", led_pin, STRETCH_EN ? 16'h0003 : 16'h0002);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (led_pin !== 16'h0000) begin errors++; $display("FAIL areset_pin got=%h want=0000", led_pin); end
        checks++;
        if (pwm_phase !== 4'h0) begin errors++; $display("FAIL areset_phase got=%h want=0", pwm_phase); end
        @(negedge clock);
        led_in  = '0;
        reset_n = 1'b1;
        @(negedge clock);
        @(negedge clock);
        checks++;
        if (led_pin !== 16'h0000) begin errors++; $display("FAIL areset_stretch_cleared got=%h want=0000", led_pin); end
        checks++;
        if (pwm_phase !== 4'h1) begin errors++; $display("FAIL areset_phase_restart got=%h want=1", pwm_phase); end
    endtask

    initial begin
        test_reset();
        test_stretch();
        test_retrigger();
        test_mask_clear();
        test_pwm();
        test_glitch_free();
        test_lamp();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/led_driver.md
# led_driver

Output stage between the LED source mux (`led_out[15:0]`) and the front-panel LED pins. It stretches short LED pulses so they are visible to the eye: for example, a single-BX cluster flag or a GBT ready glitch. It also applies global PWM dimming with glitch-free brightness updates. Everything runs in the 40 MHz logic clock domain.

## Interface
Parameters:
- `N_LEDS`, 16: number of LED channels.
- `STRETCH_CYCLES`, 4000000: extra on-time added after a channel falls (100 ms at 40 MHz). Must be ≥1.
- `PWM_BITS`, 4: width of the brightness code and PWM phase.
- `PWM_PRESCALE`, 256: clocks per PWM phase step. Must be ≥1.

Ports:
- `clock` in 1: 40 MHz logic clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `led_in` in N_LEDS: raw LED levels from the source mux.
- `stretch_mask` in N_LEDS: 1 = stretch this channel, 0 = pass through.
- `brightness` in PWM_BITS: 0 = off; all-ones = always on; otherwise duty = brightness/2^PWM_BITS.
- `lamp_test` in 1: forces all `led_pin` high, bypassing PWM and stretch.
- `led_pin` out N_LEDS: registered, active-high LED drive.
- `pwm_phase` out PWM_BITS: current PWM phase, for monitoring.

## Operation
- **Input register**
  - `in_r <= led_in` every clock.
- **Stretch**
  - One counter per channel, `cnt[i]`, width `$clog2(STRETCH_CYCLES+1)`.
  - If `stretch_mask[i]=0`: `cnt[i] <= 0`, so clearing the mask mid-stretch ends the stretch at the next edge.
  - Else if `in_r[i]=1`: `cnt[i] <= STRETCH_CYCLES`. Retriggering during a stretch reloads the counter.
  - Else if `cnt[i]≠0`: `cnt[i] <= cnt[i]-1`. The counter saturates at 0 and never wraps.
  - `stretched[i] = in_r[i] | (cnt[i]≠0)`.
- **PWM**
  - Prescaler `pre` counts 0..PWM_PRESCALE-1 and wraps. `tick = (pre==PWM_PRESCALE-1)`.
  - On `tick`, `pwm_phase` increments and wraps from all-ones to 0.
  - `bright_act` is the active brightness. It loads `brightness` only on `tick` when `pwm_phase` is all-ones, i.e. at period start. A mid-period change therefore never produces a partial-period glitch.
  - `pwm_on = (bright_act==all-ones) | (pwm_phase < bright_act)`.
- **Output**
  - `led_pin <= lamp_test ? all-ones : (stretched & {N_LEDS{pwm_on}})`.
- **Reset**
  - `reset_n` low, asynchronously: `in_r`=0, `cnt`=0, `pre`=0, `pwm_phase`=0, `bright_act`=all-ones, `led_pin`=0.
  - Release takes effect on the first clock edge after `reset_n` rises.
  - Reset asserted mid-stretch clears the stretch immediately.

## Timing
- **Latency:** a change on `led_in` appears on `led_pin` at the 2nd rising edge after it is stable (one edge into `in_r`, one into `led_pin`), at full brightness.
- **Stretch length:** if `in_r[i]` falls at edge j, an unstretched channel drops at edge j+1. A stretched channel drops at edge j+STRETCH_CYCLES+1. A 1-cycle input pulse therefore yields 1+STRETCH_CYCLES cycles high.
- **PWM period:** PWM_PRESCALE·2^PWM_BITS clocks. On-time per period is bright_act·PWM_PRESCALE clocks, or the full period for all-ones.
- **Brightness change:** takes effect within at most one PWM period plus one clock.
- **lamp_test:** affects `led_pin` one edge after it is sampled high. When deasserted, the normal path resumes on the next edge. Stretch counters keep running during lamp test.

## Configuration
- `LED_STRETCH_EN`
  - Defined: stretch counters are built as described in Operation.
  - Undefined: no counters are synthesised, `stretched = in_r`, and `stretch_mask` is ignored. Latency and PWM behaviour are unchanged.

## Test plan
The bench overrides parameters to `STRETCH_CYCLES=10`, `PWM_PRESCALE=2`, `PWM_BITS=4`, `N_LEDS=16`.

1. **Reset:** hold `reset_n`=0 with `led_in`=16'hFFFF. Expect `led_pin`=0 and `pwm_phase`=0. Release with `brightness`=4'hF; expect `led_pin`=16'hFFFF two edges later.
2. **Stretch:** `stretch_mask`=16'h0001, `brightness`=4'hF, 1-cycle pulse on `led_in`=16'h0003. Expect bit0 high for 11 cycles and bit1 high for 1 cycle, both starting at the same edge.
3. **Retrigger and mask clear:**
   - A second pulse 5 cycles after the first restarts the count: bit0 is high 16 cycles in total.
   - Clearing `stretch_mask` mid-stretch drops bit0 one edge later.
4. **PWM:** `led_in`=16'hFFFF, `brightness`=4'h4. Over a 32-clock period, expect `led_pin` high for exactly 8 clocks while `pwm_phase` is 0..3. `brightness`=0 gives 0 high clocks.
5. **Glitch-free update:** change `brightness` 4→8 while `pwm_phase`=2. The current period still gives 8 high clocks; the next period gives 16.
6. **Lamp test and async reset:**
   - `lamp_test`=1 with `led_in`=0 gives `led_pin`=16'hFFFF next edge.
   - Asserting `reset_n`=0 mid-stretch drives `led_pin` to 0 without a clock edge.
   - Build once without `LED_STRETCH_EN` and rerun scenario 2: expect bit0 high for 1 cycle only.
